conv_3x3_stream_feeder: RTL and testbench

Source-side streamer for the 3x3 convolution tops (conv_3x3_top_04_05_06 family). It reads feature-map planes and kernel weights from two synchronous single-port RAMs and emits them as the two serial streams those tops consume: a pixel stream (valid/pxl) and a weight stream (valid/weight). The iteration order is output channel outer, input channel inner. It sits between the layer memories and the conv top and is started by the layer controller with a start/busy/done handshake.

---
 rtl/conv_3x3_stream_feeder.sv | 167 ++++++++++++++++
 tb/tb_conv_3x3_stream_feeder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_3x3_stream_feeder.sv
// Streams kernel weights and feature-map planes from two single-port RAMs to a 3x3 conv top,
// output channel outer, input channel inner, with a flush gap after every pixel plane.
module conv_3x3_stream_feeder #(
   parameter int DATA_WIDTH      = 32,
   parameter int IMAGE_WIDTH     = 32,
   parameter int IMAGE_HEIGHT    = 32,
   parameter int CHANNEL_NUM_IN  = 128,
   parameter int CHANNEL_NUM_OUT = 128,
   parameter int KERNEL_SIZE     = 9,
   parameter int GAP_CYCLES      = 16,
   parameter int PXL_ADDR_WIDTH  = 17,
   parameter int WGT_ADDR_WIDTH  = 18
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   output logic                      pxl_rd_en,
   output logic [PXL_ADDR_WIDTH-1:0] pxl_rd_addr,
   input  logic [DATA_WIDTH-1:0]     pxl_rd_data,
   output logic                      wgt_rd_en,
   output logic [WGT_ADDR_WIDTH-1:0] wgt_rd_addr,
   input  logic [DATA_WIDTH-1:0]     wgt_rd_data,
   output logic                      valid_out,
   output logic [DATA_WIDTH-1:0]     pxl_out,
   output logic                      valid_weight_out,
   output logic [DATA_WIDTH-1:0]     weight_out,
   output logic                      busy,
   output logic                      done,
   output logic [2:0]                state_dbg
);

   localparam int PLANE = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int K_W   = $clog2(KERNEL_SIZE + 1);
   localparam int PIX_W = $clog2(PLANE + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int CI_W  = $clog2(CHANNEL_NUM_IN + 1);
   localparam int CO_W  = $clog2(CHANNEL_NUM_OUT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WEIGHT = 3'd1,
      S_PIXEL  = 3'd2,
      S_GAP    = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [K_W-1:0]            k;
   logic [PIX_W-1:0]          pix;
   logic [GAP_W-1:0]          gap;
   logic [CI_W-1:0]           ci;
   logic [CO_W-1:0]           co;
   logic [WGT_ADDR_WIDTH-1:0] wgt_addr;
   logic [PXL_ADDR_WIDTH-1:0] pxl_addr;
   logic [DATA_WIDTH-1:0]     wgt_hold;
   logic [DATA_WIDTH-1:0]     pxl_hold;

   logic last_k, last_pix, last_gap, last_ci, last_pair;

   assign last_k    = (k == K_W'(KERNEL_SIZE - 1));
   assign last_pix  = (pix == PIX_W'(PLANE - 1));
   assign last_gap  = (gap == GAP_W'(GAP_CYCLES - 1));
   assign last_ci   = (ci == CI_W'(CHANNEL_NUM_IN - 1));
   assign last_pair = last_ci && (co == CO_W'(CHANNEL_NUM_OUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_WEIGHT;
         S_WEIGHT: if (last_k) state_nxt = S_PIXEL;
         S_PIXEL:  if (last_pix) state_nxt = S_GAP;
         S_GAP:    if (last_gap) state_nxt = last_pair ? S_DONE : S_WEIGHT;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      wgt_rd_en = 1'b0;
      pxl_rd_en = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_WEIGHT: begin wgt_rd_en = 1'b1; busy = 1'b1; end
         S_PIXEL:  begin pxl_rd_en = 1'b1; busy = 1'b1; end
         S_GAP:    busy = 1'b1;
         S_DONE:   done = 1'b1;
         default:  ;
      endcase
   end

   // Both read addresses walk their RAMs in order, so running counters replace the products;
   // the pixel address rewinds to plane 0 each time ci wraps.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k        <= '0;
         pix      <= '0;
         gap      <= '0;
         ci       <= '0;
         co       <= '0;
         wgt_addr <= '0;
         pxl_addr <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               k        <= '0;
               pix      <= '0;
               gap      <= '0;
               ci       <= '0;
               co       <= '0;
               wgt_addr <= '0;
               pxl_addr <= '0;
            end
            S_WEIGHT: begin
               wgt_addr <= wgt_addr + WGT_ADDR_WIDTH'(1);
               k        <= last_k ? '0 : k + K_W'(1);
            end
            S_PIXEL: begin
               pxl_addr <= pxl_addr + PXL_ADDR_WIDTH'(1);
               pix      <= last_pix ? '0 : pix + PIX_W'(1);
            end
            S_GAP: begin
               gap <= last_gap ? '0 : gap + GAP_W'(1);
               if (last_gap) begin
                  if (last_ci) begin
                     ci       <= '0;
                     co       <= co + CO_W'(1);
                     pxl_addr <= '0;
                  end else begin
                     ci <= ci + CI_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_weight_out <= 1'b0;
         valid_out        <= 1'b0;
         wgt_hold         <= '0;
         pxl_hold         <= '0;
      end else begin
         valid_weight_out <= wgt_rd_en;
         valid_out        <= pxl_rd_en;
         if (valid_weight_out) wgt_hold <= wgt_rd_data;
         if (valid_out)        pxl_hold <= pxl_rd_data;
      end
   end

   // RAM data arrives one cycle after the read, so the live word is passed straight through
   // while valid and the last word is held otherwise.
   assign weight_out  = valid_weight_out ? wgt_rd_data : wgt_hold;
   assign pxl_out     = valid_out ? pxl_rd_data : pxl_hold;
   assign wgt_rd_addr = wgt_addr;
   assign pxl_rd_addr = pxl_addr;
   assign state_dbg   = state;

endmodule

// File: tb/tb_conv_3x3_stream_feeder.sv
// Bench for conv_3x3_stream_feeder: a cycle-indexed model of the two streams derived from
// the pass timing (pair n occupies cycles 1+n*P .. n*P+P) checked on every falling edge.
module tb_conv_3x3_stream_feeder;

   localparam int DW   = 16;
   localparam int W    = 4;
   localparam int H    = 4;
   localparam int CIN  = 2;
   localparam int COUT = 2;
   localparam int G    = 2;
   localparam int HW   = W * H;
   localparam int P    = 9 + HW + G;
   localparam int NP   = COUT * CIN * P;
   localparam int PAW  = 8;
   localparam int WAW  = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic           pxl_rd_en;
   logic [PAW-1:0] pxl_rd_addr;
   logic [DW-1:0]  pxl_rd_data = '0;
   logic           wgt_rd_en;
   logic [WAW-1:0] wgt_rd_addr;
   logic [DW-1:0]  wgt_rd_data = '0;
   logic           valid_out;
   logic [DW-1:0]  pxl_out;
   logic           valid_weight_out;
   logic [DW-1:0]  weight_out;
   logic           busy;
   logic           done;
   logic [2:0]     state_dbg;

   int tests = 0;
   int fails = 0;

   conv_3x3_stream_feeder #(
      .DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
      .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT), .KERNEL_SIZE(9),
      .GAP_CYCLES(G), .PXL_ADDR_WIDTH(PAW), .WGT_ADDR_WIDTH(WAW)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .pxl_rd_en(pxl_rd_en), .pxl_rd_addr(pxl_rd_addr), .pxl_rd_data(pxl_rd_data),
      .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
      .valid_out(valid_out), .pxl_out(pxl_out),
      .valid_weight_out(valid_weight_out), .weight_out(weight_out),
      .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   // RAM models: data equals address, one cycle read latency
   always @(posedge clk) begin
      if (pxl_rd_en) pxl_rd_data <= DW'(pxl_rd_addr);
      if (wgt_rd_en) wgt_rd_data <= DW'(wgt_rd_addr);
   end

   // pass tracker: m_t is the cycle index within the pass, cycle 1 being the first WEIGHT cycle
   bit m_active = 1'b0;
   int m_t      = 0;
   bit was_idle;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_active = 1'b0;
         m_t      = 0;
      end else begin
         was_idle = !m_active;
         if (m_active) begin
            if (m_t == NP + 1) m_active = 1'b0;
            else               m_t++;
         end
         if (was_idle && start) begin
            m_active = 1'b1;
            m_t      = 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s t=%0d act=%0d exp=%0d", name, m_t, act, exp);
      end
   endtask

   // scoreboard: expected stream words are queued per cycle and popped by the compare
   logic [DW-1:0] exp_q[$];
   int  last_w = 0, last_p = 0;
   int  n, r;
   bit  e_vw, e_vp, e_busy, e_done;

   always @(negedge clk) begin
      if (!reset) begin
         last_w = 0;
         last_p = 0;
         exp_q.delete();
         chk("rst_valid_out", int'(valid_out), 0);
         chk("rst_valid_w", int'(valid_weight_out), 0);
         chk("rst_pxl_out", int'(pxl_out), 0);
         chk("rst_weight_out", int'(weight_out), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_done", int'(done), 0);
         chk("rst_rd_en", int'({pxl_rd_en, wgt_rd_en}), 0);
         chk("rst_addr", int'({pxl_rd_addr, wgt_rd_addr}), 0);
         chk("rst_state", int'(state_dbg), 0);
      end else begin
         e_vw = 0; e_vp = 0; e_busy = 0; e_done = 0;
         if (m_active) begin
            e_busy = (m_t >= 1 && m_t <= NP);
            e_done = (m_t == NP + 1);
            if (m_t >= 2 && m_t <= NP + 1) begin
               n = (m_t - 2) / P;
               r = (m_t - 2) % P;
               if (r < 9) begin
                  e_vw = 1; last_w = n * 9 + r;
                  exp_q.push_back(DW'(last_w));
               end else if (r < 9 + HW) begin
                  e_vp = 1; last_p = (n % CIN) * HW + (r - 9);
                  exp_q.push_back(DW'(last_p));
               end
            end
         end
         chk("valid_weight_out", int'(valid_weight_out), int'(e_vw));
         chk("valid_out", int'(valid_out), int'(e_vp));
         chk("busy", int'(busy), int'(e_busy));
         chk("done", int'(done), int'(e_done));
         chk("one_stream", int'(valid_out & valid_weight_out), 0);
         if (e_vw) chk("weight_out", int'(weight_out), int'(exp_q.pop_front()));
         else if (e_vp) chk("pxl_out", int'(pxl_out), int'(exp_q.pop_front()));
         chk("weight_hold", int'(weight_out), last_w);
         chk("pxl_hold", int'(pxl_out), last_p);
         if (m_active) begin
            if (m_t == 2)   chk("pin_w0", int'(weight_out), 0);
            if (m_t == 10)  chk("pin_w8", int'(weight_out), 8);
            if (m_t == 29)  chk("pin_w9", int'(weight_out), 9);
            if (m_t == 11)  chk("pin_p0", int'(pxl_out), 0);
            if (m_t == 26)  chk("pin_p15", int'(pxl_out), 15);
            if (m_t == 38)  chk("pin_p16", int'(pxl_out), 16);
            if (m_t == 56)  chk("pin_w18", int'(weight_out), 18);
            if (m_t == 65)  chk("pin_wrap_p0", int'(pxl_out), 0);
            if (m_t == 108) chk("pin_busy108", int'(busy), 1);
            if (m_t == 109) chk("pin_done109", int'({busy, done}), 1);
            if (m_t == 1)   chk("pin_wgt_addr0", int'({wgt_rd_en, wgt_rd_addr}), 256);
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_t(input int target);
      int budget = 400;
      while (!(m_active && m_t == target) && budget > 0) begin
         step();
         budget--;
      end
      tests++;
      if (budget == 0) begin
         fails++;
         $display("FAIL wait_t target=%0d act_t=%0d", target, m_t);
      end
   endtask

   task automatic wait_idle();
      int budget = 400;
      while (m_active && budget > 0) begin
         step();
         budget--;
      end
      tests++;
      if (budget == 0) begin
         fails++;
         $display("FAIL wait_idle act_t=%0d", m_t);
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         start = i[0];
         step();
      end
      start = 1'b0;
      reset = 1'b1;
      step();

      // full pass with an ignored start while busy, then restart in the first idle cycle
      pulse_start();
      wait_t(40);
      pulse_start();
      wait_idle();
      pulse_start();

      // abort the second pass with reset, then run a clean pass
      wait_t(50);
      reset = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      pulse_start();
      wait_idle();

      // randomized idle spacing and spurious starts during the pass
      repeat ($urandom_range(1, 5)) step();
      pulse_start();
      while (m_active && m_t < NP) begin
         start = ($urandom_range(0, 3) == 0);
         step();
      end
      start = 1'b0;
      wait_idle();
      repeat (5) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
